pic_prio_core: RTL and testbench
================================

// Module: pic_prio_core
// PURPOSE
//  Parametrised successor to the PIC control logic: a synchronous N-input priority interrupt core.
//  Holds the request, in-service and mask registers (IRR/ISR/IMR) and resolves the winning request.
//  Supports fully nested and rotating priority, plus edge- or level-triggered requests.
//  Runs the two-pulse INTA acknowledge handshake and delivers the vector, with normal or automatic EOI.
//  Sits between the raw IR lines and the CPU bus / cascade logic.
// PARAMETERS
//  NIRQ   8   number of interrupt request lines (power of 2, 2..32)
//  VBW    5   vector base width; vector = {vec_base, level}
//  LW     $clog2(NIRQ)   level index width (derived, not overridden)
// PORTS
//  clk       in   1        system clock, rising edge
//  rst_n     in   1        asynchronous active-low reset
//  ir        in   NIRQ     raw request lines, synchronous to clk
//  ltim      in   1        1 = level-triggered, 0 = rising-edge triggered
//  aeoi      in   1        1 = auto EOI on second INTA
//  imr_we    in   1        write strobe for mask register
//  imr_wd    in   NIRQ     mask write data (1 = masked)
//  eoi_cmd   in   1        single-cycle EOI command strobe
//  eoi_spec  in   1        1 = specific EOI on eoi_lvl, 0 = non-specific
//  eoi_lvl   in   LW       level for specific EOI
//  rot       in   1        with eoi_cmd: rotate priority to the cleared level
//  vec_base  in   VBW      upper vector bits
//  inta      in   1        single-cycle acknowledge strobe (two per sequence)
//  intr      out  1        interrupt request to CPU (registered)
//  vec_valid out  1        one-cycle strobe, vec valid
//  vec       out  VBW+LW   interrupt vector
//  irr,isr,imr out NIRQ    register readback
// BEHAVIOUR
//  Reset: irr=isr=imr=0; lp=NIRQ-1 (IR0 highest); state=IDLE; intr=vec_valid=0; vec=0; ir_q=0.
//  Request capture:
//   Edge mode: irr[i] set on ir[i]&~ir_q[i]; it stays set until acknowledged.
//   Level mode: irr[i]=ir[i] each cycle.
//   Masking does not block capture.
//  Priority order: (lp+1)%NIRQ highest, wrapping through lp lowest.
//   cand = highest-priority bit of irr&~imr.
//   cur = highest-priority set bit of isr.
//  intr <= (state==IDLE) && cand exists && (isr==0 || cand outranks cur). One cycle latency.
//   Equal or lower priority than cur is blocked (fully nested).
//  FSM IDLE->ACK1->IDLE:
//   IDLE, inta && intr: latch lvl=cand; set isr[lvl]; clear irr[lvl] (edge mode); intr<=0; go ACK1.
//     If cand vanished between intr and inta: spurious. lvl=NIRQ-1, isr unchanged.
//   IDLE, inta && !intr: ignored.
//   ACK1, inta: vec<={vec_base,lvl}; vec_valid<=1 for one cycle. If aeoi && !spurious: clear isr[lvl].
//     If aeoi && rot: lp<=lvl. Go IDLE.
//   intr is held 0 in ACK1; it re-evaluates the cycle after return to IDLE.
//  EOI, accepted in any state:
//   Non-specific clears cur; with rot, lp<=cur. No-op if isr==0.
//   Specific clears isr[eoi_lvl]; with rot, lp<=eoi_lvl.
//  Same-cycle conflicts:
//   EOI and ACK set on the same bit: the set wins.
//   Different bits: both apply.
//   imr_we takes effect next cycle.
//  rst_n low mid-sequence: immediate return to reset state; no vec_valid issued.
// TESTING
//  T1 edge: ir[3] pulse, imr=0 -> intr=1 next cycle; 2x inta -> isr=0x08, vec={vec_base,3}, vec_valid 1 cycle.
//  T2 nesting: ISR[3] active, raise ir[5] -> intr stays 0.
//     Then raise ir[1] -> intr=1; ack gives isr=0x0A.
//  T3 rotate: ir[0],ir[1] pending, ack IR0, EOI non-spec + rot -> lp=0.
//     ir[0] re-raised -> IR1 now serviced first.
//  T4 AEOI + mask: aeoi=1, imr=0x04, ir[2]&ir[6] -> IR6 served, isr=0 after 2nd inta; irr[2] stays set.
//  T5 spurious: level mode, ir[4] drops after intr, before inta -> vec={vec_base,NIRQ-1}, isr unchanged.
//  T6 reset: assert rst_n low during ACK1 -> all outputs 0, no vec_valid, state IDLE.

Source files
------------

// File: rtl/pic_prio_core.sv
// Parametrised priority interrupt core: IRR/ISR/IMR, nested or rotating priority,
// two-pulse INTA acknowledge with vector delivery and normal or automatic EOI.
module pic_prio_core #(
    parameter int NIRQ = 8,
    parameter int VBW  = 5,
    localparam int LW  = $clog2(NIRQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIRQ-1:0]   ir,
    input  logic              ltim,
    input  logic              aeoi,
    input  logic              imr_we,
    input  logic [NIRQ-1:0]   imr_wd,
    input  logic              eoi_cmd,
    input  logic              eoi_spec,
    input  logic [LW-1:0]     eoi_lvl,
    input  logic              rot,
    input  logic [VBW-1:0]    vec_base,
    input  logic              inta,
    output logic              intr,
    output logic              vec_valid,
    output logic [VBW+LW-1:0] vec,
    output logic [NIRQ-1:0]   irr,
    output logic [NIRQ-1:0]   isr,
    output logic [NIRQ-1:0]   imr,
    output logic              fsm_state
);

    typedef enum logic {IDLE = 1'b0, ACK1 = 1'b1} state_t;

    // Handshake: inta is a single-cycle strobe; the first one (taken only while intr
    // is high in IDLE) latches the level, the second one delivers vec with vec_valid.
    state_t          state, state_n;
    logic [NIRQ-1:0] ir_q;
    logic [LW-1:0]   lp, lvl;
    logic            spurious;
    logic            take, done;
    logic            cand_ok, cur_ok, outranks;
    logic [LW-1:0]   cand, cur;
    logic [NIRQ-1:0] ack_set, eoi_clr, aeoi_clr, edges;

    // Scan from lowest to highest priority so the last hit is the winner.
    function automatic logic [LW:0] pick(input logic [NIRQ-1:0] v, input logic [LW-1:0] low);
        logic [LW:0]   r;
        logic [LW-1:0] i;
        r = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            i = low + LW'(k) + LW'(1);
            if (v[i]) r = {1'b1, i};
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] rank(input logic [LW-1:0] idx, input logic [LW-1:0] low);
        return idx - low - LW'(1);
    endfunction

    assign {cand_ok, cand} = pick(irr & ~imr, lp);
    assign {cur_ok, cur}   = pick(isr, lp);
    assign outranks        = rank(cand, lp) < rank(cur, lp);
    assign fsm_state       = (state == ACK1);

    always_comb begin
        state_n = state;
        take    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (inta && intr) begin
                take    = 1'b1;
                state_n = ACK1;
            end
            ACK1: if (inta) begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        edges    = ir & ~ir_q;
        ack_set  = (take && cand_ok) ? (NIRQ'(1) << cand) : '0;
        aeoi_clr = (done && aeoi && !spurious) ? (NIRQ'(1) << lvl) : '0;
        eoi_clr  = '0;
        if (eoi_cmd) begin
            if (eoi_spec)    eoi_clr = NIRQ'(1) << eoi_lvl;
            else if (cur_ok) eoi_clr = NIRQ'(1) << cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= '0;
            irr       <= '0;
            isr       <= '0;
            imr       <= '0;
            lp        <= LW'(NIRQ - 1);
            lvl       <= '0;
            spurious  <= 1'b0;
            intr      <= 1'b0;
            vec_valid <= 1'b0;
            vec       <= '0;
        end else begin
            ir_q <= ir;
            if (ltim) irr <= ir;
            else      irr <= (irr & ~ack_set) | edges;
            // An ACK setting a bit overrides any clear aimed at the same bit.
            isr <= (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
            if (imr_we) imr <= imr_wd;
            if (eoi_cmd && rot && eoi_spec)        lp <= eoi_lvl;
            else if (eoi_cmd && rot && cur_ok)     lp <= cur;
            else if (done && aeoi && rot)          lp <= lvl;
            if (take) begin
                lvl      <= cand_ok ? cand : LW'(NIRQ - 1);
                spurious <= !cand_ok;
            end
            intr      <= (state == IDLE) && !take && cand_ok && (!cur_ok || outranks);
            vec_valid <= done;
            if (done) vec <= {vec_base, lvl};
        end
    end

endmodule

// File: tb/tb_pic_prio_core.sv
// Directed bench for pic_prio_core (NIRQ=8, VBW=5): edge/level capture, nesting,
// rotation, AEOI with masking, spurious acknowledge and reset during ACK1.
module tb_pic_prio_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir, imr_wd, irr, isr, imr;
    logic       ltim, aeoi, imr_we, eoi_cmd, eoi_spec, rot, inta;
    logic [2:0] eoi_lvl;
    logic [4:0] vec_base;
    logic       intr, vec_valid, fsm_state;
    logic [7:0] vec;
    int         n_assert = 0;
    int         n_fail   = 0;

    pic_prio_core #(.NIRQ(8), .VBW(5)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .aeoi(aeoi),
        .imr_we(imr_we), .imr_wd(imr_wd), .eoi_cmd(eoi_cmd), .eoi_spec(eoi_spec),
        .eoi_lvl(eoi_lvl), .rot(rot), .vec_base(vec_base), .inta(inta),
        .intr(intr), .vec_valid(vec_valid), .vec(vec), .irr(irr), .isr(isr),
        .imr(imr), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_ir(input logic [7:0] v);
        ir = v;
        tick();
        ir = 8'h00;
        tick();
    endtask

    task automatic ack2();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic eoi(input logic s, input logic [2:0] l, input logic r);
        eoi_cmd = 1'b1; eoi_spec = s; eoi_lvl = l; rot = r;
        tick();
        eoi_cmd = 1'b0; eoi_spec = 1'b0; eoi_lvl = 3'd0; rot = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ir = '0; ltim = 1'b0; aeoi = 1'b0; imr_we = 1'b0; imr_wd = '0;
        eoi_cmd = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0; rot = 1'b0; inta = 1'b0;
        vec_base = 5'h15;
        tick(); tick();
        chk("rst_intr", intr, 0);
        chk("rst_vv", vec_valid, 0);
        chk("rst_vec", vec, 0);
        chk("rst_regs", {irr, isr, imr}, 0);
        chk("rst_state", fsm_state, 0);
        rst_n = 1'b1;
        tick();

        // T1 edge capture and full acknowledge
        ir = 8'h08;
        tick();
        chk("t1_irr", irr, 8'h08);
        chk("t1_intr_lat", intr, 0);
        ir = 8'h00;
        tick();
        chk("t1_intr", intr, 1);
        ack2();
        chk("t1_vv", vec_valid, 1);
        chk("t1_vec", vec, 8'hAB);
        chk("t1_isr", isr, 8'h08);
        chk("t1_irr_clr", irr, 8'h00);
        tick();
        chk("t1_vv_off", vec_valid, 0);

        // T2 fully nested: lower priority blocked, higher nests
        pulse_ir(8'h20);
        tick();
        chk("t2_blocked", intr, 0);
        chk("t2_irr", irr, 8'h20);
        pulse_ir(8'h02);
        chk("t2_nest_intr", intr, 1);
        ack2();
        chk("t2_vec", vec, 8'hA9);
        chk("t2_isr", isr, 8'h0A);
        tick();
        eoi(1'b0, 3'd0, 1'b0);
        chk("t2_nseoi1", isr, 8'h08);
        eoi(1'b0, 3'd0, 1'b0);
        chk("t2_nseoi2", isr, 8'h00);
        tick();
        chk("t2_ir5_intr", intr, 1);
        ack2();
        chk("t2_vec5", vec, 8'hAD);
        tick();
        eoi(1'b1, 3'd5, 1'b0);
        chk("t2_seoi", isr, 8'h00);

        // T3 rotation
        pulse_ir(8'h03);
        chk("t3_intr", intr, 1);
        ack2();
        chk("t3_vec0", vec, 8'hA8);
        chk("t3_isr0", isr, 8'h01);
        chk("t3_irr", irr, 8'h02);
        tick();
        chk("t3_ir1_blocked", intr, 0);
        eoi(1'b0, 3'd0, 1'b1);
        chk("t3_isr_clr", isr, 8'h00);
        pulse_ir(8'h01);
        tick();
        chk("t3_intr2", intr, 1);
        ack2();
        chk("t3_vec1_first", vec, 8'hA9);
        chk("t3_isr1", isr, 8'h02);
        chk("t3_irr0", irr, 8'h01);
        tick();
        eoi(1'b0, 3'd0, 1'b1);
        tick();
        chk("t3_intr3", intr, 1);
        ack2();
        chk("t3_vec0b", vec, 8'hA8);
        tick();
        eoi(1'b1, 3'd0, 1'b0);
        eoi(1'b1, 3'd7, 1'b1);
        chk("t3_isr_end", isr, 8'h00);

        // T4 AEOI with masked IR2
        aeoi = 1'b1; imr_we = 1'b1; imr_wd = 8'h04;
        tick();
        imr_we = 1'b0;
        chk("t4_imr", imr, 8'h04);
        pulse_ir(8'h44);
        chk("t4_intr", intr, 1);
        chk("t4_irr", irr, 8'h44);
        ack2();
        chk("t4_vec", vec, 8'hAE);
        chk("t4_vv", vec_valid, 1);
        chk("t4_isr", isr, 8'h00);
        chk("t4_irr2", irr, 8'h04);
        tick();
        chk("t4_masked", intr, 0);
        aeoi = 1'b0; ltim = 1'b1;
        tick(); tick();
        chk("t4_lvl_irr", irr, 8'h00);
        chk("t4_lvl_intr", intr, 0);

        // T5 spurious acknowledge in level mode
        ir = 8'h10;
        tick(); tick();
        chk("t5_intr", intr, 1);
        ir = 8'h00;
        tick();
        chk("t5_irr_gone", irr, 8'h00);
        chk("t5_intr_held", intr, 1);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk("t5_isr_unch", isr, 8'h00);
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk("t5_vec", vec, 8'hAF);
        chk("t5_vv", vec_valid, 1);
        chk("t5_isr", isr, 8'h00);
        tick();

        // T6 reset during ACK1
        ltim = 1'b0;
        pulse_ir(8'h08);
        chk("t6_intr", intr, 1);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk("t6_state", fsm_state, 1);
        chk("t6_isr", isr, 8'h08);
        rst_n = 1'b0;
        #1;
        chk("t6_async_state", fsm_state, 0);
        chk("t6_async_out", {intr, vec_valid, vec}, 0);
        chk("t6_async_regs", {irr, isr, imr}, 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk("t6_no_vv", vec_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_post_vv", vec_valid, 0);
        chk("t6_post_intr", intr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
